seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore-style serial pattern detector, successor to the fixed 0101 detector.
- Pattern and pattern length are run-time programmable up to MAX_LEN bits, with selectable overlapping or non-overlapping detection and a saturating match counter.
- Sits on a 1-bit serial data stream gated by a sample enable. A control/CSR block programs it through a load strobe.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- LEN_W, 4, width of pat_len; must hold MAX_LEN.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; in is sampled only on edges where en=1.
- in  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; latches pattern, pat_len and overlap.
- pattern  in  MAX_LEN  target pattern. Bit [pat_len-1] is the first bit received; bit [0] is the last.
- pat_len  in  LEN_W  pattern length in bits.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- out  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (reset=0, asynchronous): clears pat_q, len_q, ovl_q, history shift register hist, fill counter fill, out and match_cnt. The block stays idle until the first cfg_load.
- cfg_load=1 on an edge:
  - pat_q<=pattern, ovl_q<=overlap.
  - len_q<=pat_len, clamped to MAX_LEN if larger.
  - hist and fill are cleared; out<=0.
  - Any sample presented in the same cycle is discarded.
- Sample (en=1, cfg_load=0):
  - hist<={hist[MAX_LEN-2:0],in}.
  - fill<=min(fill+1,MAX_LEN).
- Match condition, combinational on the post-shift value:
  - len_q≠0;
  - fill_next≥len_q;
  - the low len_q bits of hist_next equal the low len_q bits of pat_q.
- out (Moore, registered):
  - Goes high in the cycle after the edge that sampled the final pattern bit, for exactly one cycle per match.
  - out=0 on any edge with en=0, so it never holds across stalls.
- Overlap handling on a match:
  - ovl_q=1: hist and fill keep advancing normally. Example: 0101 detected twice in 010101.
  - ovl_q=0: fill<=0 on the matching edge, so bits of a matched pattern are never reused. Example: 0101 detected once in 0101 01, then again only after 4 fresh bits.
- en=0: hist, fill and match_cnt hold; out<=0.
- len_q=0: detection is disabled; out stays 0 and match_cnt holds.
- len_q=1: single-bit compare; every matching sample pulses out.
- match_cnt:
  - Increments on each edge where out is set to 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 has priority over a simultaneous increment; the result is 0.
- cfg_load simultaneous with a would-be match: cfg_load wins. There is no match and no count.
- Reset asserted mid-stream: all state clears immediately. After release, detection needs a fresh cfg_load; partial history is never reused.
- Sequential logic uses a single always block sensitive to posedge clk and negedge reset. All outputs are flops.

Test Plan:
- Reset, cfg_load pattern=8'b0000_0101, pat_len=4, overlap=1; stream in=0,1,0,1,0,1 with en=1 → out pulses one cycle after the 4th and 6th samples; match_cnt=2.
- Same config with overlap=0, stream 0,1,0,1,0,1,0,1 → out pulses after the 4th and 8th samples only; match_cnt=2.
- pattern 0101, en toggled 0 between every sample (stream 0,_,1,_,0,_,1) → a single pulse after the last enabled 1; out=0 during every en=0 cycle; hist unchanged across stalls.
- pat_len=8, pattern=8'hA5 streamed MSB-first after 3 junk bits → exactly one pulse, after the 11th sample; pat_len=9 (>MAX_LEN) behaves as len 8.
- CNT_W=2, overlap=1, pattern=1'b1 with pat_len=1, stream of six 1s → match_cnt saturates at 3; cnt_clr asserted on the 6th sample edge → match_cnt=0.
- Mid-stream checks:
  - After 0,1,0 of pattern 0101, assert reset low for one cycle → out=0, match_cnt=0; subsequent 1 produces no match.
  - Separately, cfg_load coincident with the final 1 → no pulse, count unchanged.

Source files
------------

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap control and a
// saturating match counter. Out is a registered Moore pulse.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               in_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   pat_len_i,
    input  logic               overlap_i,
    input  logic               cnt_clr_i,
    output logic               out_o,
    output logic [CNT_W-1:0]   match_cnt_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    assign hist_next = {hist_q[MAX_LEN-2:0], in_i};
    assign fill_next = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);

    // Only the low len_q history bits take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (len_q > LEN_W'(gi));
    end

    assign hit = (len_q != '0) && (fill_next >= len_q) &&
                 (((hist_next ^ pat_q) & len_mask) == '0);

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        cnt_d  = cnt_q;

        if (cfg_load_i) begin
            pat_d  = pattern_i;
            len_d  = (pat_len_i > MAX_LEN_L) ? MAX_LEN_L : pat_len_i;
            ovl_d  = overlap_i;
            hist_d = '0;
            fill_d = '0;
        end else if (en_i) begin
            hist_d = hist_next;
            fill_d = fill_next;
            if (hit) begin
                out_d = 1'b1;
                // Non-overlapping mode forgets the bits just consumed.
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end

        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_o       = out_q;
    assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of sampled bits.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .in_i       (din),
        .cfg_load_i (cfg_load),
        .pattern_i  (pattern),
        .pat_len_i  (pat_len),
        .overlap_i  (overlap),
        .cnt_clr_i  (cnt_clr),
        .out_o      (out),
        .match_cnt_o(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bits sampled since the last config load (or since
    // the last match in non-overlapping mode), oldest first.
    bit [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               avail[$];
    bit               exp_out;
    int               exp_cnt;

    int    n_checks;
    int    n_fail;
    int    n_step;
    string tag;

    function automatic bit model_match();
        if (m_len == 0) return 1'b0;
        if (avail.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (avail[avail.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pat = '0;
        m_len = 0;
        m_ovl = 1'b0;
        avail.delete();
        exp_out = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic model_edge();
        if (cfg_load) begin
            m_pat = pattern;
            m_len = (int'(pat_len) > MAX_LEN) ? MAX_LEN : int'(pat_len);
            m_ovl = overlap;
            avail.delete();
            exp_out = 1'b0;
        end else if (en) begin
            avail.push_back(din);
            if (avail.size() > MAX_LEN) void'(avail.pop_front());
            exp_out = model_match();
            if (exp_out && !m_ovl) avail.delete();
        end else begin
            exp_out = 1'b0;
        end
        if (cnt_clr) exp_cnt = 0;
        else if (exp_out && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic check_outputs();
        n_checks++;
        assert (out === exp_out) else begin
            n_fail++;
            $error("FAIL %s step %0d out: got %b expected %b", tag, n_step, out, exp_out);
        end
        n_checks++;
        assert (match_cnt === CNT_W'(exp_cnt)) else begin
            n_fail++;
            $error("FAIL %s step %0d match_cnt: got %0d expected %0d", tag, n_step, match_cnt, exp_cnt);
        end
    endtask

    task automatic check_cnt_const(input int want);
        n_checks++;
        assert (match_cnt === CNT_W'(want)) else begin
            n_fail++;
            $error("FAIL %s directed match_cnt: got %0d expected %0d", tag, match_cnt, want);
        end
    endtask

    task automatic step(input bit e, input bit d, input bit ld, input bit clr);
        en       = e;
        din      = d;
        cfg_load = ld;
        cnt_clr  = clr;
        @(posedge clk);
        model_edge();
        #1;
        n_step++;
        $display("step %0d %s en=%b in=%b ld=%b clr=%b -> out=%b cnt=%0d", n_step, tag, e, d, ld, clr,
                 out, match_cnt);
        check_outputs();
    endtask

    task automatic load(input bit [MAX_LEN-1:0] p, input bit [LEN_W-1:0] l, input bit o);
        pattern = p;
        pat_len = l;
        overlap = o;
        step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        en = 1'b0; din = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        $display("reset applied and released at %0t", $time);
    endtask

    task automatic stream(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; n_step = 0;
        pattern = '0; pat_len = '0; overlap = 1'b0;
        tag = "reset";
        do_reset();

        tag = "idle";
        stream(16'b0101, 4);
        check_cnt_const(0);

        tag = "ovl";
        load(8'b0000_0101, 4'd4, 1'b1);
        stream(16'b010101, 6);
        check_cnt_const(2);

        tag = "novl";
        load(8'b0000_0101, 4'd4, 1'b0);
        stream(16'b01010101, 8);
        check_cnt_const(2);

        tag = "stall";
        load(8'b0000_0101, 4'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_cnt_const(1);

        tag = "len8";
        load(8'hA5, 4'd8, 1'b1);
        stream(16'b000_1010_0101, 11);
        check_cnt_const(1);

        tag = "len9";
        load(8'hA5, 4'd9, 1'b1);
        stream(16'b000_1010_0101, 11);
        check_cnt_const(1);

        tag = "sat";
        load(8'h01, 4'd1, 1'b1);
        stream(16'b11111, 5);
        check_cnt_const(3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_cnt_const(0);

        tag = "len0";
        load(8'h00, 4'd0, 1'b1);
        stream(16'b0000, 4);
        check_cnt_const(0);

        tag = "midrst";
        load(8'b0000_0101, 4'd4, 1'b1);
        stream(16'b010, 3);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_cnt_const(0);

        tag = "cfgwin";
        load(8'b0000_0101, 4'd4, 1'b1);
        stream(16'b010, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_cnt_const(0);
        stream(16'b0101, 4);
        check_cnt_const(1);

        tag = "rand";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                pattern = MAX_LEN'($urandom);
                pat_len = ($urandom_range(0, 15) == 0) ? LEN_W'($urandom_range(9, 15))
                                                       : LEN_W'($urandom_range(0, 4));
                overlap = 1'($urandom);
                step(1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom),
                     ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
